cpa_pipelined_adder: RTL

//   Final carry-propagate adder of the multiplier datapath, directly downstream
//   of the counter/compressor tree. Adds the two rows left by the tree (sum row,

---
 rtl/cpa_pipelined_adder_if.sv | 24 ++
 rtl/cpa_pipelined_adder.sv | 101 ++++++++++
 2 files changed

// File: rtl/cpa_pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined final carry-propagate adder.
// The adder is the slave; the producer/consumer side (compressor tree, product sink) is the master.
interface cpa_pipelined_adder_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] row_s;
  logic [W-1:0] row_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, row_s, row_c, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, row_s, row_c, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/cpa_pipelined_adder.sv
// Final carry-propagate adder: sums the compressor tree's sum and carry rows one
// CHUNK-bit slice per stage, rippling the carry down a stall-as-one-unit pipeline.
module cpa_pipelined_adder #(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cpa_pipelined_adder_if.slave bus
);

  localparam int STAGES = W / CHUNK;
  localparam int NB     = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int BW     = (STAGES > 1) ? W - CHUNK : 1;

  if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_cfg
    $error("cpa_pipelined_adder: W must be a nonzero multiple of CHUNK");
  end

  // One slice of the ripple: returns {carry_out, slice_sum}.
  function automatic logic [CHUNK:0] add_slice(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  endfunction

  logic          advance;
  logic [W-1:0]  a_nxt  [STAGES];
  logic [BW-1:0] b_nxt  [STAGES];
  logic          cy_nxt [STAGES];

  // a_p: finished low slices plus the untouched upper slices of row_s.
  // b_p: the row_c slices still to be added, shifted down so the next one sits at bit 0.
  logic [W-1:0]  a_p   [NB];
  logic [BW-1:0] b_p   [NB];
  logic          cy_p  [NB];
  logic          vld_p [NB];

  logic [W-1:0]  out_sum_q;
  logic          out_cout_q;
  logic          out_vld_q;

  assign advance      = ~out_vld_q | bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_nxt[k]  = '0;
      b_nxt[k]  = '0;
      cy_nxt[k] = 1'b0;
    end
    // Stage 0: capture operands and add slice 0 with no carry-in.
    a_nxt[0] = bus.row_s;
    {cy_nxt[0], a_nxt[0][CHUNK-1:0]} = add_slice(bus.row_s[CHUNK-1:0], bus.row_c[CHUNK-1:0], 1'b0);
    b_nxt[0] = BW'(bus.row_c >> CHUNK);
    // Stage k: add slice k of the delayed operands plus the carry from stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      a_nxt[k] = a_p[k-1];
      {cy_nxt[k], a_nxt[k][k*CHUNK +: CHUNK]} =
        add_slice(a_p[k-1][k*CHUNK +: CHUNK], b_p[k-1][CHUNK-1:0], cy_p[k-1]);
      b_nxt[k] = b_p[k-1] >> CHUNK;
    end
  end

  // Intermediate stage data: valid bits alone decide whether it means anything.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < NB; k++) begin
        a_p[k]  <= a_nxt[k];
        b_p[k]  <= b_nxt[k];
        cy_p[k] <= cy_nxt[k];
      end
    end
  end

  // Stage valids and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++) begin
        vld_p[k] <= 1'b0;
      end
      out_vld_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k < NB; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      out_vld_q  <= (STAGES > 1) ? vld_p[NB-1] : bus.in_valid;
      out_sum_q  <= a_nxt[STAGES-1];
      out_cout_q <= cy_nxt[STAGES-1];
    end
  end

endmodule
